// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads the combinational instruction
// memory, buffers words in a shift-style prefetch FIFO and hands them to decode
// over a valid/ready handshake. Branch redirects flush the buffer.
module instruction_fetch_unit #(
    parameter int unsigned        ADDR_W     = 16,
    parameter int unsigned        DATA_W     = 32,
    parameter int unsigned        FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter int unsigned        MEM_WORDS  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] inst_address,
    input  logic [DATA_W-1:0] read_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              fault
);

    localparam int unsigned     CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_WORDS);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_FAULT = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] pc_q, pc_n;
    entry_t            fifo_q [FIFO_DEPTH];
    entry_t            fifo_n [FIFO_DEPTH];
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic              valid_q;
    logic              fault_q, fault_n;

    logic              pop_c;
    logic              push_c;
    logic              full_c;
    logic              in_range_c;
    logic              target_ok_c;
    logic [CNT_W-1:0]  wr_idx_c;

    // Next-state, FIFO update and fetch PC advance; slot 0 is always the head.
    always_comb begin
        state_n  = state_q;
        pc_n     = pc_q;
        fault_n  = fault_q;
        cnt_n    = cnt_q;
        fifo_n   = fifo_q;

        in_range_c  = ({1'b0, pc_q} < MEM_LIMIT);
        target_ok_c = ({1'b0, redirect_target} < MEM_LIMIT);
        full_c      = (cnt_q == CNT_W'(FIFO_DEPTH));
        pop_c       = valid_q & inst_ready & ~redirect_valid;
        push_c      = (state_q == S_FETCH) & in_range_c & (~full_c | pop_c) & ~redirect_valid;
        wr_idx_c    = cnt_q - CNT_W'(pop_c);

        if (redirect_valid) begin
            cnt_n = '0;
            pc_n  = redirect_target;
            if (target_ok_c) begin
                state_n = S_FETCH;
                fault_n = 1'b0;
            end else begin
                state_n = S_FAULT;
                fault_n = 1'b1;
            end
        end else begin
            if (pop_c) begin
                for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
                    fifo_n[i] = fifo_q[i+1];
                end
            end
            if (push_c) begin
                for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                    if (CNT_W'(i) == wr_idx_c) begin
                        fifo_n[i] = '{pc: pc_q, data: read_data};
                    end
                end
                pc_n = pc_q + ADDR_W'(1);
            end
            cnt_n = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
            if ((state_q == S_FETCH) && !in_range_c) begin
                state_n = S_FAULT;
                fault_n = 1'b1;
            end
        end
    end

    // State, PC, FIFO and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            cnt_q   <= cnt_n;
            valid_q <= (cnt_n != '0);
            fault_q <= fault_n;
            fifo_q  <= fifo_n;
        end
    end

    assign inst_address = pc_q;
    assign inst_valid   = valid_q;
    assign inst_data    = fifo_q[0].data;
    assign inst_pc      = fifo_q[0].pc;
    assign fault        = fault_q;

endmodule
